img_rom_arbiter: RTL and testbench

IMG_ROM_ARBITER -- requirements
Module: img_rom_arbiter

---
 rtl/img_rom_pkg.sv | 28 ++
 rtl/img_rom_rd_pipe.sv | 41 ++++
 rtl/img_rom_arbiter.sv | 171 +++++++++++++++++
 tb/tb_img_rom_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_rom_pkg.sv
// img_rom_pkg: shared widths, defaults and enums for the image ROM arbiter.
package img_rom_pkg;

    localparam int unsigned ADDR_W_DEF    = 13;
    localparam int unsigned DATA_W_DEF    = 8;
    localparam int unsigned MEM_DEPTH_DEF = 4800;
    localparam int unsigned TIMEOUT_DEF   = 1024;
    localparam int unsigned WAIT_W        = 16;

    // Owner of a memory cycle, carried down the read-return pipeline.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_DISP = 2'd1,
        GNT_HOST = 2'd2
    } grant_owner_t;

    // Host handshake: ARMED accepts a request, HOLD waits for host_req to drop.
    typedef enum logic {
        HS_ARMED = 1'b0,
        HS_HOLD  = 1'b1
    } host_hs_t;

    // Saturating increment for the wait counter.
    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
        return (v == '1) ? v : v + WAIT_W'(1);
    endfunction

endpackage

// File: rtl/img_rom_rd_pipe.sv
// img_rom_rd_pipe: two-stage owner pipeline that steers memory read data
// to the display or the host port two cycles after the grant decision.
module img_rom_rd_pipe
    import img_rom_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
)(
    input  logic              clk,
    input  logic              rst,
    input  grant_owner_t      i_owner,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [DATA_W-1:0] o_disp_data,
    output logic              o_disp_valid,
    output logic [DATA_W-1:0] o_host_rdata,
    output logic              o_host_rvalid
);

    grant_owner_t r_own_s1;
    grant_owner_t r_own_s2;
    logic         w_disp_hit;
    logic         w_host_hit;

    // Stage 1 aligns with the memory command, stage 2 with returned data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_own_s1 <= GNT_NONE;
            r_own_s2 <= GNT_NONE;
        end else begin
            r_own_s1 <= i_owner;
            r_own_s2 <= r_own_s1;
        end
    end

    assign w_disp_hit    = (r_own_s2 == GNT_DISP);
    assign w_host_hit    = (r_own_s2 == GNT_HOST);
    assign o_disp_valid  = w_disp_hit;
    assign o_host_rvalid = w_host_hit;
    assign o_disp_data   = w_disp_hit ? i_mem_rdata : '0;
    assign o_host_rdata  = w_host_hit ? i_mem_rdata : '0;

endmodule

// File: rtl/img_rom_arbiter.sv
// img_rom_arbiter: single-port image memory shared by a display fetch port
// (absolute priority) and a host read/write port. Grants are decided in the
// request cycle, the memory command is registered one cycle later and read
// data returns one cycle after that.
// Optional feature: define IMG_ARB_TIMEOUT_EN to abort host requests that
// wait TIMEOUT cycles (host_ack + host_err, no memory access).
module img_rom_arbiter
    import img_rom_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEF
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_disp_req,
    input  logic [ADDR_W-1:0] i_disp_addr,
    output logic [DATA_W-1:0] o_disp_data,
    output logic              o_disp_valid,
    input  logic              i_host_req,
    input  logic              i_host_we,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [DATA_W-1:0] i_host_wdata,
    output logic              o_host_ack,
    output logic [DATA_W-1:0] o_host_rdata,
    output logic              o_host_rvalid,
    output logic              o_host_err,
    output logic [WAIT_W-1:0] o_host_wait_max,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

`ifdef IMG_ARB_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    host_hs_t          r_hs_state;
    host_hs_t          w_hs_next;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] r_wait_max;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic              w_host_oor;
    logic              w_to_hit;
    logic              w_disp_gnt;
    logic              w_host_ack;
    logic              w_host_err;
    logic              w_host_mem;
    logic              w_host_wait;
    grant_owner_t      w_owner;

    // Host address outside the image and wait-limit detection.
    assign w_host_oor = (32'(i_host_addr) >= MEM_DEPTH);
    assign w_to_hit   = TIMEOUT_EN && (32'(r_wait_cnt) >= TIMEOUT);

    // Host handshake state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hs_state <= HS_ARMED;
        end else begin
            r_hs_state <= w_hs_next;
        end
    end

    // Grant decision, host handshake next state and read-return owner.
    always_comb begin
        w_hs_next   = r_hs_state;
        w_disp_gnt  = 1'b0;
        w_host_ack  = 1'b0;
        w_host_err  = 1'b0;
        w_host_mem  = 1'b0;
        w_host_wait = 1'b0;
        w_owner     = GNT_NONE;
        if (!rst) begin
            w_disp_gnt = i_disp_req;
            case (r_hs_state)
                HS_ARMED: begin
                    if (i_host_req) begin
                        if (!i_disp_req) begin
                            w_host_ack = 1'b1;
                            w_host_err = w_host_oor;
                            w_host_mem = !w_host_oor;
                        end else if (w_to_hit) begin
                            w_host_ack = 1'b1;
                            w_host_err = 1'b1;
                        end
                        w_host_wait = !w_host_ack;
                        if (w_host_ack) begin
                            w_hs_next = HS_HOLD;
                        end
                    end
                end
                HS_HOLD: begin
                    if (!i_host_req) begin
                        w_hs_next = HS_ARMED;
                    end
                end
                default: w_hs_next = HS_ARMED;
            endcase
            if (w_disp_gnt) begin
                w_owner = GNT_DISP;
            end else if (w_host_mem && !i_host_we) begin
                w_owner = GNT_HOST;
            end
        end
    end

    // Wait counter and worst-case wait tracking, folded in on every host ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_wait_max <= '0;
        end else if (w_host_ack) begin
            r_wait_cnt <= '0;
            if (r_wait_cnt > r_wait_max) begin
                r_wait_max <= r_wait_cnt;
            end
        end else if (w_host_wait) begin
            r_wait_cnt <= sat_inc(r_wait_cnt);
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // Registered memory command, one cycle after the grant decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_en    <= w_disp_gnt | w_host_mem;
            r_mem_we    <= w_host_mem & i_host_we;
            r_mem_addr  <= w_disp_gnt ? i_disp_addr
                         : (w_host_mem ? i_host_addr : '0);
            r_mem_wdata <= (w_host_mem & i_host_we) ? i_host_wdata : '0;
        end
    end

    img_rom_rd_pipe #(
        .DATA_W (DATA_W)
    ) u_rd_pipe (
        .clk           (clk),
        .rst           (rst),
        .i_owner       (w_owner),
        .i_mem_rdata   (i_mem_rdata),
        .o_disp_data   (o_disp_data),
        .o_disp_valid  (o_disp_valid),
        .o_host_rdata  (o_host_rdata),
        .o_host_rvalid (o_host_rvalid)
    );

    assign o_host_ack      = w_host_ack;
    assign o_host_err      = w_host_err;
    assign o_host_wait_max = r_wait_max;
    assign o_mem_en        = r_mem_en;
    assign o_mem_we        = r_mem_we;
    assign o_mem_addr      = r_mem_addr;
    assign o_mem_wdata     = r_mem_wdata;

endmodule

// File: tb/tb_img_rom_arbiter.sv
// tb_img_rom_arbiter: directed bench for img_rom_arbiter with a behavioural
// single-port write-first memory (read latency 1).
module tb_img_rom_arbiter;
    import img_rom_pkg::*;

    localparam int unsigned AW = 13;
    localparam int unsigned DW = 8;
`ifdef IMG_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_data;
    logic          disp_valid;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ack;
    logic [DW-1:0] host_rdata;
    logic          host_rvalid;
    logic          host_err;
    logic [15:0]   host_wait_max;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] mem [0:8191];

    always #5 clk = ~clk;

    img_rom_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .i_disp_req      (disp_req),
        .i_disp_addr     (disp_addr),
        .o_disp_data     (disp_data),
        .o_disp_valid    (disp_valid),
        .i_host_req      (host_req),
        .i_host_we       (host_we),
        .i_host_addr     (host_addr),
        .i_host_wdata    (host_wdata),
        .o_host_ack      (host_ack),
        .o_host_rdata    (host_rdata),
        .o_host_rvalid   (host_rvalid),
        .o_host_err      (host_err),
        .o_host_wait_max (host_wait_max),
        .o_mem_en        (mem_en),
        .o_mem_we        (mem_we),
        .o_mem_addr      (mem_addr),
        .o_mem_wdata     (mem_wdata),
        .i_mem_rdata     (mem_rdata)
    );

    function automatic logic [DW-1:0] pat(input int a);
        return DW'((a * 13 + 7) % 256);
    endfunction

    // Memory model: preset contents, write-first, one-cycle read latency.
    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = pat(i);
        mem_rdata <= '0;
        forever begin
            @(posedge clk);
            if (mem_en) begin
                if (mem_we) mem[mem_addr] = mem_wdata;
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; disp_req = 1'b1; disp_addr = AW'(3);
        host_req = 1'b1; host_we = 1'b0; host_addr = AW'(100); host_wdata = '0;
        next_cycle(); next_cycle();
        settle();
        n_cmp++; if (host_ack !== 1'b0) begin n_bad++; $display("FAIL rst_ack got %0b want 0", host_ack); end
        n_cmp++; if (host_err !== 1'b0) begin n_bad++; $display("FAIL rst_err got %0b want 0", host_err); end
        n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL rst_mem_en got %0b want 0", mem_en); end
        n_cmp++; if (disp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_disp_valid got %0b want 0", disp_valid); end
        n_cmp++; if (host_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid got %0b want 0", host_rvalid); end
        n_cmp++; if (host_wait_max !== 16'd0) begin n_bad++; $display("FAIL rst_wait_max got %0d want 0", host_wait_max); end
        next_cycle();
        // pending host read is granted on the first cycle out of reset
        rst = 1'b0; disp_req = 1'b0;
        settle();
        n_cmp++; if (host_ack !== 1'b1) begin n_bad++; $display("FAIL post_rst_ack got %0b want 1", host_ack); end
        n_cmp++; if (host_err !== 1'b0) begin n_bad++; $display("FAIL post_rst_err got %0b want 0", host_err); end
        next_cycle();
        host_req = 1'b0;
        settle();
        n_cmp++; if (host_ack !== 1'b0) begin n_bad++; $display("FAIL rd_c1_ack got %0b want 0", host_ack); end
        n_cmp++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin n_bad++; $display("FAIL rd_c1_en_we got %0b%0b want 10", mem_en, mem_we); end
        n_cmp++; if (mem_addr !== AW'(100)) begin n_bad++; $display("FAIL rd_c1_addr got %0d want 100", mem_addr); end
        n_cmp++; if (host_rvalid !== 1'b0) begin n_bad++; $display("FAIL rd_c1_rvalid got %0b want 0", host_rvalid); end
        next_cycle();
        settle();
        n_cmp++; if (host_rvalid !== 1'b1) begin n_bad++; $display("FAIL rd_c2_rvalid got %0b want 1", host_rvalid); end
        n_cmp++; if (host_rdata !== pat(100)) begin n_bad++; $display("FAIL rd_c2_rdata got %0h want %0h", host_rdata, pat(100)); end
        next_cycle();
        settle();
        n_cmp++; if (host_rvalid !== 1'b0) begin n_bad++; $display("FAIL rd_c3_rvalid got %0b want 0", host_rvalid); end
        next_cycle();
    endtask

    task automatic test_disp_stream();
        host_req = 1'b1; host_we = 1'b0; host_addr = AW'(200);
        for (int i = 0; i < 80; i++) begin
            disp_req = 1'b1; disp_addr = AW'(i);
            settle();
            n_cmp++; if (host_ack !== 1'b0) begin n_bad++; $display("FAIL stream_ack[%0d] got %0b want 0", i, host_ack); end
            if (i >= 2) begin
                n_cmp++; if (disp_valid !== 1'b1) begin n_bad++; $display("FAIL stream_valid[%0d] got %0b want 1", i, disp_valid); end
                n_cmp++; if (disp_data !== pat(i - 2)) begin n_bad++; $display("FAIL stream_data[%0d] got %0h want %0h", i, disp_data, pat(i - 2)); end
            end else begin
                n_cmp++; if (disp_valid !== 1'b0) begin n_bad++; $display("FAIL stream_valid[%0d] got %0b want 0", i, disp_valid); end
            end
            next_cycle();
        end
        disp_req = 1'b0;
        settle();
        n_cmp++; if (host_ack !== 1'b1) begin n_bad++; $display("FAIL stream_gap_ack got %0b want 1", host_ack); end
        n_cmp++; if (disp_data !== pat(78)) begin n_bad++; $display("FAIL stream_tail78 got %0h want %0h", disp_data, pat(78)); end
        next_cycle();
        host_req = 1'b0;
        settle();
        n_cmp++; if (disp_data !== pat(79)) begin n_bad++; $display("FAIL stream_tail79 got %0h want %0h", disp_data, pat(79)); end
        n_cmp++; if (host_wait_max !== 16'd80) begin n_bad++; $display("FAIL stream_wait_max got %0d want 80", host_wait_max); end
        n_cmp++; if (mem_addr !== AW'(200)) begin n_bad++; $display("FAIL stream_host_addr got %0d want 200", mem_addr); end
        next_cycle();
        settle();
        n_cmp++; if (host_rvalid !== 1'b1 || host_rdata !== pat(200)) begin n_bad++; $display("FAIL stream_host_rd got %0b/%0h want 1/%0h", host_rvalid, host_rdata, pat(200)); end
        n_cmp++; if (disp_valid !== 1'b0) begin n_bad++; $display("FAIL stream_end_valid got %0b want 0", disp_valid); end
        next_cycle();
    endtask

    task automatic test_write_then_disp();
        disp_req = 1'b0; host_req = 1'b1; host_we = 1'b1; host_addr = AW'(5); host_wdata = 8'hA5;
        settle();
        n_cmp++; if (host_ack !== 1'b1 || host_err !== 1'b0) begin n_bad++; $display("FAIL wr_ack_err got %0b%0b want 10", host_ack, host_err); end
        next_cycle();
        host_req = 1'b0; host_we = 1'b0; disp_req = 1'b1; disp_addr = AW'(5);
        settle();
        n_cmp++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin n_bad++; $display("FAIL wr_en_we got %0b%0b want 11", mem_en, mem_we); end
        n_cmp++; if (mem_addr !== AW'(5) || mem_wdata !== 8'hA5) begin n_bad++; $display("FAIL wr_addr_data got %0d/%0h want 5/a5", mem_addr, mem_wdata); end
        next_cycle();
        disp_req = 1'b0;
        settle();
        n_cmp++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin n_bad++; $display("FAIL wr_disp_cmd got %0b%0b want 10", mem_en, mem_we); end
        n_cmp++; if (host_rvalid !== 1'b0) begin n_bad++; $display("FAIL wr_no_rvalid got %0b want 0", host_rvalid); end
        next_cycle();
        settle();
        n_cmp++; if (disp_valid !== 1'b1 || disp_data !== 8'hA5) begin n_bad++; $display("FAIL wr_readback got %0b/%0h want 1/a5", disp_valid, disp_data); end
        n_cmp++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin n_bad++; $display("FAIL idle_cmd got %0b%0b want 00", mem_en, mem_we); end
        next_cycle();
    endtask

    task automatic test_out_of_range();
        disp_req = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = AW'(4800);
        settle();
        n_cmp++; if (host_ack !== 1'b1 || host_err !== 1'b1) begin n_bad++; $display("FAIL oor_ack_err got %0b%0b want 11", host_ack, host_err); end
        next_cycle();
        host_req = 1'b0;
        settle();
        n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL oor_mem_en got %0b want 0", mem_en); end
        n_cmp++; if (host_err !== 1'b0 || host_ack !== 1'b0) begin n_bad++; $display("FAIL oor_pulse_len got %0b%0b want 00", host_ack, host_err); end
        next_cycle();
        settle();
        n_cmp++; if (host_rvalid !== 1'b0) begin n_bad++; $display("FAIL oor_rvalid got %0b want 0", host_rvalid); end
        next_cycle();
        host_req = 1'b1; host_addr = AW'(4799);
        settle();
        n_cmp++; if (host_ack !== 1'b1 || host_err !== 1'b0) begin n_bad++; $display("FAIL last_ack_err got %0b%0b want 10", host_ack, host_err); end
        next_cycle();
        host_req = 1'b0;
        settle();
        n_cmp++; if (mem_en !== 1'b1 || mem_addr !== AW'(4799)) begin n_bad++; $display("FAIL last_cmd got %0b/%0d want 1/4799", mem_en, mem_addr); end
        next_cycle();
        settle();
        n_cmp++; if (host_rvalid !== 1'b1 || host_rdata !== pat(4799)) begin n_bad++; $display("FAIL last_rd got %0b/%0h want 1/%0h", host_rvalid, host_rdata, pat(4799)); end
        next_cycle();
    endtask

    task automatic test_hold_no_double();
        disp_req = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = AW'(10);
        settle();
        n_cmp++; if (host_ack !== 1'b1) begin n_bad++; $display("FAIL hold_h0_ack got %0b want 1", host_ack); end
        next_cycle();
        settle();
        n_cmp++; if (host_ack !== 1'b0) begin n_bad++; $display("FAIL hold_h1_ack got %0b want 0", host_ack); end
        next_cycle();
        settle();
        n_cmp++; if (host_ack !== 1'b0 || mem_en !== 1'b0) begin n_bad++; $display("FAIL hold_h2 ack/en got %0b/%0b want 0/0", host_ack, mem_en); end
        n_cmp++; if (host_rvalid !== 1'b1 || host_rdata !== pat(10)) begin n_bad++; $display("FAIL hold_h2_rd got %0b/%0h want 1/%0h", host_rvalid, host_rdata, pat(10)); end
        next_cycle();
        host_req = 1'b0;
        settle();
        n_cmp++; if (host_ack !== 1'b0 || host_rvalid !== 1'b0) begin n_bad++; $display("FAIL hold_h3 ack/rvalid got %0b/%0b want 0/0", host_ack, host_rvalid); end
        next_cycle();
        host_req = 1'b1;
        settle();
        n_cmp++; if (host_ack !== 1'b1) begin n_bad++; $display("FAIL hold_h4_ack got %0b want 1", host_ack); end
        next_cycle();
        host_req = 1'b0;
        next_cycle();
        settle();
        n_cmp++; if (host_rvalid !== 1'b1 || host_rdata !== pat(10)) begin n_bad++; $display("FAIL hold_h6_rd got %0b/%0h want 1/%0h", host_rvalid, host_rdata, pat(10)); end
        next_cycle();
    endtask

    task automatic test_wait_max();
        rst = 1'b1; disp_req = 1'b0; host_req = 1'b0;
        next_cycle();
        rst = 1'b0;
        settle();
        n_cmp++; if (host_wait_max !== 16'd0) begin n_bad++; $display("FAIL wmax_clear got %0d want 0", host_wait_max); end
        next_cycle();
        host_req = 1'b1; host_we = 1'b0; host_addr = AW'(20);
        for (int k = 0; k < 50; k++) begin
            disp_req = 1'b1; disp_addr = AW'(k);
            settle();
            n_cmp++; if (host_ack !== 1'b0) begin n_bad++; $display("FAIL wmax_ack[%0d] got %0b want 0", k, host_ack); end
            next_cycle();
        end
        disp_req = 1'b0;
        settle();
        n_cmp++; if (host_ack !== 1'b1) begin n_bad++; $display("FAIL wmax_first_free got %0b want 1", host_ack); end
        next_cycle();
        host_req = 1'b0;
        settle();
        n_cmp++; if (host_wait_max !== 16'd50) begin n_bad++; $display("FAIL wmax_50 got %0d want 50", host_wait_max); end
        next_cycle();
    endtask

    task automatic test_long_wait();
        logic exp_hit;
        host_req = 1'b1; host_we = 1'b0; host_addr = AW'(30);
        for (int k = 0; k < 1100; k++) begin
            disp_req = 1'b1; disp_addr = AW'(k);
            exp_hit = TO_EN && (k == 1024);
            settle();
            n_cmp++; if (host_ack !== exp_hit || host_err !== exp_hit) begin n_bad++; $display("FAIL long_ack_err[%0d] got %0b%0b want %0b%0b", k, host_ack, host_err, exp_hit, exp_hit); end
            next_cycle();
        end
        disp_req = 1'b0;
        settle();
        n_cmp++; if (host_ack !== !TO_EN || host_err !== 1'b0) begin n_bad++; $display("FAIL long_release got %0b%0b want %0b0", host_ack, host_err, !TO_EN); end
        next_cycle();
        host_req = 1'b0;
        settle();
        n_cmp++; if (host_wait_max !== (TO_EN ? 16'd1024 : 16'd1100)) begin n_bad++; $display("FAIL long_wait_max got %0d want %0d", host_wait_max, TO_EN ? 1024 : 1100); end
        next_cycle();
        next_cycle();
    endtask

    task automatic test_reset_mid_read();
        disp_req = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = AW'(300);
        settle();
        n_cmp++; if (host_ack !== 1'b1) begin n_bad++; $display("FAIL mid_ack got %0b want 1", host_ack); end
        next_cycle();
        host_req = 1'b0; rst = 1'b1;
        settle();
        n_cmp++; if (mem_en !== 1'b1) begin n_bad++; $display("FAIL mid_mem_en got %0b want 1", mem_en); end
        next_cycle();
        rst = 1'b0;
        settle();
        n_cmp++; if (host_rvalid !== 1'b0 || mem_en !== 1'b0) begin n_bad++; $display("FAIL mid_flush got %0b/%0b want 0/0", host_rvalid, mem_en); end
        next_cycle();
        settle();
        n_cmp++; if (host_rvalid !== 1'b0) begin n_bad++; $display("FAIL mid_late_rvalid got %0b want 0", host_rvalid); end
        next_cycle();
        disp_req = 1'b1; disp_addr = AW'(7);
        next_cycle();
        disp_req = 1'b0; rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        settle();
        n_cmp++; if (disp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_disp_valid got %0b want 0", disp_valid); end
        next_cycle();
    endtask

    initial begin
        rst = 1'b1; disp_req = 1'b0; disp_addr = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        test_reset();
        test_disp_stream();
        test_write_then_disp();
        test_out_of_range();
        test_hold_no_double();
        test_wait_max();
        test_long_wait();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
